// File: rtl/wave_weight_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : wave_weight_sequencer_pkg
// Brief  : Shared state encoding and width constants for the weight sequencer.
// Rev    : 1.0
// ============================================================================
package wave_weight_sequencer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int COL_IDX_WIDTH      = 3;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int MAG_WIDTH          = DEFAULT_DATA_WIDTH - 1;

  // Magnitude drops the sign bit; keep the relation in one place.
  function automatic int mag_width(input int data_width);
    return data_width - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wave_weight_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : wave_weight_sequencer_if
// Brief  : Weight-vector input and bit-column output handshakes.
// Rev    : 1.0
// ============================================================================
interface wave_weight_sequencer_if
  import wave_weight_sequencer_pkg::*;
#(
  parameter int VEC_LENGTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                         w_valid;
  logic                         w_ready;
  logic                         w_load;
  logic signed [DATA_WIDTH-1:0] weight [VEC_LENGTH];

  logic                         col_valid;
  logic                         col_ready;
  logic                         sign     [VEC_LENGTH];
  logic                         w_bit    [VEC_LENGTH];
  logic [COL_IDX_WIDTH-1:0]     column_idx;
  logic                         load_accum;
  logic                         last;

  // master: weight producer and column consumer; slave: the sequencer
  modport master (
    output w_valid, w_load, weight, col_ready,
    input  w_ready, col_valid, sign, w_bit, column_idx, load_accum, last
  );

  modport slave (
    input  w_valid, w_load, weight, col_ready,
    output w_ready, col_valid, sign, w_bit, column_idx, load_accum, last
  );
endinterface
`default_nettype wire

// File: rtl/wave_weight_sequencer_lane_sign_mag.sv
`default_nettype none
// ============================================================================
// Module : lane_sign_mag
// Brief  : Two's complement to sign/magnitude, most negative value saturates.
// Rev    : 1.0
// ============================================================================
module lane_sign_mag #(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] i_value,
  output logic                         o_sign,
  output logic        [DATA_WIDTH-2:0] o_magnitude
);
  localparam logic [DATA_WIDTH-2:0] c_one = 1;

  logic [DATA_WIDTH-2:0] w_low;

  assign w_low  = i_value[DATA_WIDTH-2:0];
  assign o_sign = i_value[DATA_WIDTH-1];

  always_comb begin
    if (!o_sign)
      o_magnitude = w_low;
    else if (w_low == '0)
      o_magnitude = '1;  // -2^(N-1) has no positive twin
    else
      o_magnitude = ~w_low + c_one;
  end
endmodule
`default_nettype wire

// File: rtl/wave_weight_sequencer.sv
`default_nettype none
// ============================================================================
// Module : wave_weight_sequencer
// Brief  : Streams set magnitude bit-columns of a weight vector, MSB first.
// Rev    : 1.0
// ============================================================================
module wave_weight_sequencer
  import wave_weight_sequencer_pkg::*;
#(
  parameter int VEC_LENGTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  wave_weight_sequencer_if.slave  bus
);
  localparam int MW = mag_width(DATA_WIDTH);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_EMIT = EMIT;

  logic [0:0]               r_state;
  logic [MW-1:0]            r_mask;
  logic [MW-1:0]            r_mag  [VEC_LENGTH];
  logic                     r_sign [VEC_LENGTH];
  logic [COL_IDX_WIDTH-1:0] r_idx;
  logic                     r_load;

  logic [MW-1:0]            w_mag  [VEC_LENGTH];
  logic                     w_sign [VEC_LENGTH];
  logic [MW-1:0]            w_acc_mask;
  logic [MW-1:0]            w_below;
  logic [COL_IDX_WIDTH-1:0] w_next_idx;
  logic                     w_last;
  logic                     w_emit;
  logic                     w_accept;

  function automatic logic [COL_IDX_WIDTH-1:0] top_bit(input logic [MW-1:0] v);
    logic [COL_IDX_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < MW; k++)
      if (v[k]) r = COL_IDX_WIDTH'(k);
    return r;
  endfunction

  generate
    for (genvar j = 0; j < VEC_LENGTH; j++) begin : g_lane
      lane_sign_mag #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .i_value     (bus.weight[j]),
        .o_sign      (w_sign[j]),
        .o_magnitude (w_mag[j])
      );
    end
  endgenerate

  always_comb begin
    w_acc_mask = '0;
    for (int j = 0; j < VEC_LENGTH; j++)
      w_acc_mask = w_acc_mask | w_mag[j];
  end

  // Only set columns strictly below the current one are candidates.
  always_comb begin
    w_below = '0;
    for (int k = 0; k < MW; k++)
      w_below[k] = r_mask[k] && (COL_IDX_WIDTH'(k) < r_idx);
  end

  assign w_next_idx = top_bit(w_below);
  assign w_last     = ~|w_below;
  assign w_emit     = (r_state == ST_EMIT);

  assign bus.w_ready = ~w_emit | (w_last & bus.col_ready);
  assign w_accept    = bus.w_valid & bus.w_ready;

  always_comb begin
    bus.col_valid  = w_emit;
    bus.last       = w_emit & w_last;
    bus.column_idx = w_emit ? r_idx : '0;
    bus.load_accum = w_emit & r_load;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      bus.sign[j]  = w_emit & r_sign[j];
      bus.w_bit[j] = w_emit & r_mag[j][r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_idx   <= '0;
      r_load  <= 1'b0;
      for (int j = 0; j < VEC_LENGTH; j++) begin
        r_mag[j]  <= '0;
        r_sign[j] <= 1'b0;
      end
    end else if (w_accept) begin
      r_state <= ST_EMIT;
      r_mask  <= w_acc_mask;
      r_idx   <= top_bit(w_acc_mask);
      r_load  <= bus.w_load;
      for (int j = 0; j < VEC_LENGTH; j++) begin
        r_mag[j]  <= w_mag[j];
        r_sign[j] <= w_sign[j];
      end
    end else if (w_emit && bus.col_ready) begin
      // load_accum belongs to the first column only
      r_load <= 1'b0;
      if (w_last)
        r_state <= ST_IDLE;
      else
        r_idx <= w_next_idx;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_wave_weight_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_wave_weight_sequencer
// Brief  : Table-driven vectors plus column scoreboard and corner sequences.
// Rev    : 1.0
// ============================================================================
module tb_wave_weight_sequencer;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] bits;
    logic [7:0] sgn;
    logic       load;
    logic       last;
  } col_t;

  typedef struct {
    logic [7:0][7:0] w;
    logic            load;
    int              exp_cols;
    int              exp_first;
  } vec_t;

  logic clk;
  logic reset;

  wave_weight_sequencer_if #(.VEC_LENGTH(8), .DATA_WIDTH(8)) bus ();

  wave_weight_sequencer #(.VEC_LENGTH(8), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests;
  int         fails;
  col_t       exp_q [$];
  col_t       snap;
  bit         stall_pending;
  int         vec_cols;
  logic [2:0] first_idx_seen;
  vec_t       tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic col_t sample();
    col_t c;
    c.idx  = bus.column_idx;
    c.load = bus.load_accum;
    c.last = bus.last;
    for (int j = 0; j < 8; j++) begin
      c.bits[j] = bus.w_bit[j];
      c.sgn[j]  = bus.sign[j];
    end
    return c;
  endfunction

  // Reference model: one queue entry per column the sequencer must present.
  function automatic void push_expected(input logic [7:0][7:0] w, input logic ld);
    int         mag [8];
    int         v;
    int         lowest;
    logic [6:0] mask;
    logic [7:0] sg;
    bit         first;
    col_t       c;
    mask   = '0;
    sg     = '0;
    lowest = 0;
    first  = 1'b1;
    for (int j = 0; j < 8; j++) begin
      v      = $signed(w[j]);
      sg[j]  = (v < 0);
      mag[j] = (v < 0) ? -v : v;
      if (mag[j] > 127) mag[j] = 127;
      mask   = mask | 7'(mag[j]);
    end
    if (mask == '0) begin
      c = '{idx: 3'd0, bits: 8'h00, sgn: sg, load: ld, last: 1'b1};
      exp_q.push_back(c);
    end else begin
      for (int k = 6; k >= 0; k--)
        if (mask[k]) lowest = k;
      for (int k = 6; k >= 0; k--) begin
        if (mask[k]) begin
          c.idx = 3'(k);
          for (int j = 0; j < 8; j++) c.bits[j] = 1'((mag[j] >> k) & 1);
          c.sgn  = sg;
          c.load = ld && first;
          c.last = (k == lowest);
          exp_q.push_back(c);
          first  = 1'b0;
        end
      end
    end
  endfunction

  // Column monitor: scoreboard pops on handshake, stalls must hold outputs.
  always @(negedge clk) begin
    col_t act;
    col_t e;
    if (bus.col_valid === 1'b1) begin
      act = sample();
      if (stall_pending) check("stall_hold", 32'(act), 32'(snap));
      if (bus.col_ready === 1'b1) begin
        stall_pending = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_col", 32'(act), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("col_idx",  32'(act.idx),  32'(e.idx));
          check("col_bits", 32'(act.bits), 32'(e.bits));
          check("col_sign", 32'(act.sgn),  32'(e.sgn));
          check("col_load", 32'(act.load), 32'(e.load));
          check("col_last", 32'(act.last), 32'(e.last));
        end
        if (vec_cols == 0) first_idx_seen = act.idx;
        vec_cols++;
      end else begin
        snap          = act;
        stall_pending = 1'b1;
      end
    end else begin
      stall_pending = 1'b0;
    end
  end

  task automatic send(input logic [7:0][7:0] w, input logic ld, output bit in_last);
    int n;
    in_last     = 1'b0;
    bus.w_valid = 1'b1;
    bus.w_load  = ld;
    for (int j = 0; j < 8; j++) bus.weight[j] = w[j];
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.w_ready !== 1'b1 && n < 100);
    if (bus.w_ready !== 1'b1) begin
      check("accept_timeout", 32'(bus.w_ready), 32'h1);
    end else begin
      in_last = bus.col_valid && bus.last;
      push_expected(w, ld);
    end
    @(posedge clk);
    #1;
    bus.w_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.col_valid === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'(exp_q.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit         f;
    col_t       r;
    logic [7:0][7:0] wa;
    logic [7:0][7:0] wb;
    tests         = 0;
    fails         = 0;
    vec_cols      = 0;
    stall_pending = 1'b0;
    reset         = 1'b0;
    bus.w_valid   = 1'b0;
    bus.w_load    = 1'b0;
    bus.col_ready = 1'b1;
    for (int j = 0; j < 8; j++) bus.weight[j] = '0;

    for (int i = 0; i < 6; i++) tbl[i].w = '0;
    tbl[0].w[0] = 8'd3;   tbl[0].w[1] = 8'hFB;
    tbl[0].load = 1'b1;   tbl[0].exp_cols = 3; tbl[0].exp_first = 2;
    tbl[1].load = 1'b0;   tbl[1].exp_cols = 1; tbl[1].exp_first = 0;
    tbl[2].w[0] = 8'h80;
    tbl[2].load = 1'b1;   tbl[2].exp_cols = 7; tbl[2].exp_first = 6;
    tbl[3].w = {8'h02, 8'h80, 8'h00, 8'h11, 8'hC0, 8'h40, 8'hFF, 8'h7F};
    tbl[3].load = 1'b0;   tbl[3].exp_cols = 7; tbl[3].exp_first = 6;
    tbl[4].w = {8{8'h01}};
    tbl[4].load = 1'b1;   tbl[4].exp_cols = 1; tbl[4].exp_first = 0;
    tbl[5].w[0] = 8'h08;  tbl[5].w[7] = 8'hF0;
    tbl[5].load = 1'b0;   tbl[5].exp_cols = 2; tbl[5].exp_first = 4;

    repeat (3) @(posedge clk);
    @(negedge clk);
    r = sample();
    check("rst_col_valid", 32'(bus.col_valid), 32'h0);
    check("rst_last",      32'(r.last),        32'h0);
    check("rst_load",      32'(r.load),        32'h0);
    check("rst_idx",       32'(r.idx),         32'h0);
    check("rst_w_bit",     32'(r.bits),        32'h0);
    check("rst_sign",      32'(r.sgn),         32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rel_w_ready",   32'(bus.w_ready),   32'h1);
    check("rel_col_valid", 32'(bus.col_valid), 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      vec_cols = 0;
      send(tbl[i].w, tbl[i].load, f);
      wait_idle();
      check("tbl_ncols", 32'(vec_cols),       32'(tbl[i].exp_cols));
      check("tbl_first", 32'(first_idx_seen), 32'(tbl[i].exp_first));
    end

    // col_ready 1,0,0,1 on the consuming edges after the first column appears
    vec_cols = 0;
    send(tbl[0].w, 1'b1, f);
    @(posedge clk); #1 bus.col_ready = 1'b0;
    @(posedge clk); #1 bus.col_ready = 1'b0;
    @(posedge clk); #1 bus.col_ready = 1'b1;
    wait_idle();
    check("stall_ncols", 32'(vec_cols), 32'h3);

    // second vector offered while the first is still emitting
    wa = tbl[0].w;
    wb = '0;
    wb[2] = 8'h01;
    vec_cols = 0;
    send(wa, 1'b0, f);
    send(wb, 1'b1, f);
    check("b2b_accept_in_last", 32'(f), 32'h1);
    @(negedge clk);
    check("b2b_no_bubble", 32'(bus.col_valid),  32'h1);
    check("b2b_idx",       32'(bus.column_idx), 32'h0);
    check("b2b_load",      32'(bus.load_accum), 32'h1);
    wait_idle();
    check("b2b_ncols", 32'(vec_cols), 32'h4);

    // reset while the second of three columns is on the bus
    send(tbl[0].w, 1'b1, f);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.col_ready = 1'b0;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    check("rst_mid_col_valid", 32'(bus.col_valid), 32'h0);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.col_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_stale", 32'(bus.col_valid), 32'h0);
      check("rst_mid_w_ready",  32'(bus.w_ready),   32'h1);
    end
    @(posedge clk);
    #1;
    vec_cols = 0;
    send(tbl[5].w, 1'b1, f);
    wait_idle();
    check("post_rst_ncols", 32'(vec_cols), 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wave_weight_sequencer.md
WAVE_WEIGHT_SEQUENCER -- requirements
Module: wave_weight_sequencer

Interface
REQ-001 SHALL have parameter VEC_LENGTH, default 8: number of weight lanes, equal to the MAC vector length.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: weight width, two's complement.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port w_valid, input, 1: a weight vector is offered.
REQ-006 SHALL have port w_ready, output, 1: the sequencer accepts the weight vector this cycle.
REQ-007 SHALL have port weight, input, signed DATA_WIDTH x VEC_LENGTH unpacked: the weight vector.
REQ-008 SHALL have port w_load, input, 1: sampled with the weight vector; the first column of that vector asserts load_accum.
REQ-009 SHALL have port col_valid, output, 1: a column is presented.
REQ-010 SHALL have port col_ready, input, 1: the MAC side consumes the column.
REQ-011 SHALL have port sign, output, 1 x VEC_LENGTH unpacked: per-lane weight sign.
REQ-012 SHALL have port w_bit, output, 1 x VEC_LENGTH unpacked: per-lane magnitude bit of the current column.
REQ-013 SHALL have port column_idx, output, 3: bit position of the current column, 0..DATA_WIDTH-2.
REQ-014 SHALL have port load_accum, output, 1: asserted only on the first column of a vector whose w_load was 1.
REQ-015 SHALL have port last, output, 1: the current column is the final column of the vector.

Function
REQ-016 SHALL convert each lane on accept to sign = weight MSB and magnitude = |weight|, saturating -2^(DATA_WIDTH-1) to magnitude 2^(DATA_WIDTH-1)-1 (-128 -> 127).
REQ-017 SHALL compute a column mask on accept: bit k is set iff any lane magnitude has bit k set, for k = 0..DATA_WIDTH-2.
REQ-018 SHALL emit only the set columns, in descending k order (MSB first); all-zero columns are skipped and consume no cycle.
REQ-019 SHALL emit exactly one column when all magnitudes are zero: column_idx=0, w_bit all 0, last=1, load_accum=w_load.
REQ-020 SHALL use FSM states IDLE and EMIT: IDLE->EMIT on w_valid&w_ready; EMIT->IDLE on col_valid&col_ready&last with no new accept; EMIT->EMIT otherwise.
REQ-021 SHALL drive w_ready = (state==IDLE) | (state==EMIT & last & col_ready), allowing back-to-back vectors with zero bubble.
REQ-022 SHALL drive col_valid=1 exactly in EMIT; the first column appears the cycle after accept (latency 1).
REQ-023 SHALL hold sign, w_bit, column_idx, load_accum and last stable while col_valid=1 & col_ready=0.
REQ-024 SHALL advance to the next lower set column on col_valid&col_ready; the lowest set column carries last=1.
REQ-025 SHALL hold sign constant for all columns of a vector and drive w_bit[j] = magnitude[j][column_idx].
REQ-026 SHALL ignore w_valid while w_ready=0; weight and w_load are not sampled then.

Reset
REQ-027 SHALL, on reset=0 at a clk edge, enter IDLE and clear the mask, magnitudes, signs, and load flag.
REQ-028 SHALL hold these output values during and after reset: col_valid=0, last=0, load_accum=0, column_idx=0, w_bit all 0, sign all 0, w_ready=1 after release.
REQ-029 SHALL, if reset is asserted mid-vector, discard the remaining columns with no partial emission after release.

Structure
REQ-030 SHALL place in the shared package: the state enum (IDLE, EMIT), the column-index width constant (3), and the magnitude width constant (DATA_WIDTH-1).
REQ-031 SHALL use one sub-module, lane_sign_mag: combinational two's complement to sign/magnitude with saturation, instantiated per lane.
REQ-032 SHALL implement next-column selection as a priority search over the mask below the current column_idx.

Verification
REQ-033 SHALL cover: weights {3,-5,0,0,0,0,0,0}, w_load=1, col_ready=1 -> columns idx 2 (w_bit 01000000 lane order 0..7, i.e. lane1), idx1 (lane0), idx0 (lanes 0,1, last=1); load_accum only on idx2; sign lane1=1.
REQ-034 SHALL cover: all weights 0 -> one column idx0, w_bit 0, last=1.
REQ-035 SHALL cover: weight -128 in lane0 -> magnitude 127, columns 6..0 all emitted (7 columns), sign[0]=1.
REQ-036 SHALL cover: col_ready toggling 1,0,0,1 -> outputs frozen during the stalls, no column lost or duplicated.
REQ-037 SHALL cover: second vector offered during the last column with col_ready=1 -> accepted the same cycle, its first column next cycle with no bubble.
REQ-038 SHALL cover: reset=0 during the second of three columns -> col_valid=0 next cycle, w_ready=1 after release, no stale column.
